// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the IF/LSU unified memory port arbiter.
//   arb_state_t : transaction FSM state (IDLE -> REQ -> WAIT -> IDLE)
//   arb_owner_t : which requester owns the current memory transaction
//   starve_w()  : width needed to hold a starvation count of 0..MAX_STARVE
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_LSU = 1'b0,
    OWN_IF  = 1'b1
  } arb_owner_t;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MAX_STARVE = 4;

  // Counter width able to represent the saturation value itself.
  function automatic int starve_w(input int max_starve);
    if (max_starve < 1) begin
      return 1;
    end else begin
      return $clog2(max_starve + 1);
    end
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Purely combinational arbitration decision, evaluated by the top in IDLE.
// LSU has priority; once IF has lost MAX_STARVE consecutive contested
// arbitrations it wins the next one.
// Ports:
//   i_if_req, i_ls_req  : pending requests
//   i_starve_cnt        : current count of consecutive IF losses
//   o_valid             : at least one request pending
//   o_owner             : winner of this arbitration
//   o_starve_cnt_nxt    : starvation count to store if this decision is taken
// -----------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_STARVE = DEF_MAX_STARVE,
  parameter int STARVE_W   = starve_w(DEF_MAX_STARVE)
) (
  input  logic                i_if_req,
  input  logic                i_ls_req,
  input  logic [STARVE_W-1:0] i_starve_cnt,
  output logic                o_valid,
  output arb_owner_t          o_owner,
  output logic [STARVE_W-1:0] o_starve_cnt_nxt
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

  logic w_starved;
  logic [STARVE_W-1:0] w_starve_inc;

  // Saturating increment; >= guards against any count beyond the limit.
  always_comb begin
    w_starved = (i_starve_cnt >= STARVE_MAX);
    if (w_starved) begin
      w_starve_inc = STARVE_MAX;
    end else begin
      w_starve_inc = i_starve_cnt + {{(STARVE_W-1){1'b0}}, 1'b1};
    end
  end

  // Winner selection and starvation bookkeeping.
  always_comb begin
    o_valid          = i_if_req | i_ls_req;
    o_owner          = OWN_LSU;
    o_starve_cnt_nxt = i_starve_cnt;
    if (i_if_req && i_ls_req) begin
      if (w_starved) begin
        o_owner          = OWN_IF;
        o_starve_cnt_nxt = {STARVE_W{1'b0}};
      end else begin
        o_owner          = OWN_LSU;
        o_starve_cnt_nxt = w_starve_inc;
      end
    end else if (i_if_req) begin
      o_owner          = OWN_IF;
      o_starve_cnt_nxt = {STARVE_W{1'b0}};
    end else if (i_ls_req) begin
      // IF did not compete, so the count is left alone.
      o_owner          = OWN_LSU;
      o_starve_cnt_nxt = i_starve_cnt;
    end else begin
      o_owner          = OWN_LSU;
      o_starve_cnt_nxt = i_starve_cnt;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one req/gnt/rvalid memory port between instruction fetch (IF) and the
// LSU with at most one transaction outstanding. LSU-priority arbitration with
// a starvation limit for IF (see mem_arb_pick).
// Ports:
//   i_clk, i_rst                 : clock, async active-high reset
//   i_if_req/i_if_addr           : IF read request (held until o_if_gnt)
//   o_if_gnt/o_if_rvalid/o_if_rdata : IF grant pulse, response pulse, data
//   i_ls_req/we/be/addr/wdata    : LSU request (held until o_ls_gnt)
//   o_ls_gnt/o_ls_rvalid/o_ls_rdata : LSU grant pulse, response pulse, data
//   o_mem_req/we/be/addr/wdata   : memory request and registered payload
//   i_mem_gnt/rvalid/rdata       : memory accept, response, read data
//   o_busy                       : a transaction is in flight
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_STARVE = DEF_MAX_STARVE
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_ls_req,
  input  logic                i_ls_we,
  input  logic [DATA_W/8-1:0] i_ls_be,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy
);

  localparam int BE_W     = DATA_W / 8;
  localparam int STARVE_W = starve_w(MAX_STARVE);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  arb_owner_t          r_owner;
  logic [STARVE_W-1:0] r_starve_cnt;

  logic                r_mem_we;
  logic [BE_W-1:0]     r_mem_be;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                r_if_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_ls_rvalid;
  logic [DATA_W-1:0]   r_ls_rdata;

  logic                w_pick_valid;
  arb_owner_t          w_pick_owner;
  logic [STARVE_W-1:0] w_starve_nxt;

  mem_arb_pick #(
    .MAX_STARVE (MAX_STARVE),
    .STARVE_W   (STARVE_W)
  ) u_pick (
    .i_if_req         (i_if_req),
    .i_ls_req         (i_ls_req),
    .i_starve_cnt     (r_starve_cnt),
    .o_valid          (w_pick_valid),
    .o_owner          (w_pick_owner),
    .o_starve_cnt_nxt (w_starve_nxt)
  );

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic. Requests are only looked at in IDLE, and memory
  // handshakes only in the state that expects them.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = ARB_REQ;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_REQ: begin
        if (i_mem_gnt) begin
          w_state_nxt = ARB_WAIT;
        end else begin
          w_state_nxt = ARB_REQ;
        end
      end
      ARB_WAIT: begin
        if (i_mem_rvalid) begin
          w_state_nxt = ARB_IDLE;
        end else begin
          w_state_nxt = ARB_WAIT;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // FSM outputs. The grant is passed straight through from i_mem_gnt so the
  // requester learns of acceptance in the same cycle as the memory.
  always_comb begin
    o_mem_req = 1'b0;
    o_if_gnt  = 1'b0;
    o_ls_gnt  = 1'b0;
    o_busy    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        o_busy = 1'b0;
      end
      ARB_REQ: begin
        o_mem_req = 1'b1;
        o_busy    = 1'b1;
        if (i_mem_gnt) begin
          o_if_gnt = (r_owner == OWN_IF);
          o_ls_gnt = (r_owner == OWN_LSU);
        end else begin
          o_if_gnt = 1'b0;
          o_ls_gnt = 1'b0;
        end
      end
      ARB_WAIT: begin
        o_busy = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  // Arbitration result, request payload and response capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner      <= OWN_LSU;
      r_starve_cnt <= {STARVE_W{1'b0}};
      r_mem_we     <= 1'b0;
      r_mem_be     <= {BE_W{1'b0}};
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wdata  <= {DATA_W{1'b0}};
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= {DATA_W{1'b0}};
      r_ls_rvalid  <= 1'b0;
      r_ls_rdata   <= {DATA_W{1'b0}};
    end else begin
      // Response strobes are single-cycle pulses.
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_owner      <= w_pick_owner;
            r_starve_cnt <= w_starve_nxt;
            if (w_pick_owner == OWN_IF) begin
              // Fetches are always full-word reads.
              r_mem_we    <= 1'b0;
              r_mem_be    <= {BE_W{1'b1}};
              r_mem_addr  <= i_if_addr;
              r_mem_wdata <= {DATA_W{1'b0}};
            end else begin
              r_mem_we    <= i_ls_we;
              r_mem_be    <= i_ls_be;
              r_mem_addr  <= i_ls_addr;
              r_mem_wdata <= i_ls_wdata;
            end
          end else begin
            r_owner      <= r_owner;
            r_starve_cnt <= r_starve_cnt;
          end
        end
        ARB_WAIT: begin
          if (i_mem_rvalid) begin
            if (r_owner == OWN_IF) begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= i_mem_rdata;
            end else begin
              r_ls_rvalid <= 1'b1;
              r_ls_rdata  <= i_mem_rdata;
            end
          end else begin
            r_if_rdata <= r_if_rdata;
            r_ls_rdata <= r_ls_rdata;
          end
        end
        default: begin
          r_owner <= r_owner;
        end
      endcase
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_be    = r_mem_be;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_rvalid = r_if_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_ls_rvalid = r_ls_rvalid;
  assign o_ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed self-checking bench for mem_port_arbiter (default parameters:
// 32-bit address/data, MAX_STARVE = 4). Inputs change 1 time unit after the
// rising edge; outputs are compared 1 time unit after that or after the edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_ls_req;
  logic        i_ls_we;
  logic [3:0]  i_ls_be;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_if_req     (i_if_req),
    .i_if_addr    (i_if_addr),
    .o_if_gnt     (o_if_gnt),
    .o_if_rvalid  (o_if_rvalid),
    .o_if_rdata   (o_if_rdata),
    .i_ls_req     (i_ls_req),
    .i_ls_we      (i_ls_we),
    .i_ls_be      (i_ls_be),
    .i_ls_addr    (i_ls_addr),
    .i_ls_wdata   (i_ls_wdata),
    .o_ls_gnt     (o_ls_gnt),
    .o_ls_rvalid  (o_ls_rvalid),
    .o_ls_rdata   (o_ls_rdata),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_be     (o_mem_be),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_busy       (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Hard stop in case the scripted sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Serves one transaction starting in REQ: grant, one WAIT cycle with the
  // response, then checks the response pulse and steps into the next IDLE.
  task automatic serve(input string tag, input logic exp_if, input logic [31:0] data,
                       input logic chk_data, input logic drop_if, input logic drop_ls);
    chk({tag, "_mem_req"}, {63'd0, o_mem_req}, 64'd1);
    i_mem_gnt = 1'b1;
    #1;
    chk({tag, "_if_gnt"}, {63'd0, o_if_gnt}, {63'd0, exp_if});
    chk({tag, "_ls_gnt"}, {63'd0, o_ls_gnt}, {63'd0, ~exp_if});
    tick();
    i_mem_gnt = 1'b0;
    if (drop_if) i_if_req = 1'b0;
    if (drop_ls) i_ls_req = 1'b0;
    chk({tag, "_wait_req"}, {63'd0, o_mem_req}, 64'd0);
    chk({tag, "_wait_busy"}, {63'd0, o_busy}, 64'd1);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = data;
    tick();
    i_mem_rvalid = 1'b0;
    chk({tag, "_if_rvalid"}, {63'd0, o_if_rvalid}, {63'd0, exp_if});
    chk({tag, "_ls_rvalid"}, {63'd0, o_ls_rvalid}, {63'd0, ~exp_if});
    if (chk_data) begin
      if (exp_if) chk({tag, "_if_rdata"}, {32'd0, o_if_rdata}, {32'd0, data});
      else        chk({tag, "_ls_rdata"}, {32'd0, o_ls_rdata}, {32'd0, data});
    end
    tick();
  endtask

  initial begin
    i_rst = 1'b1;
    i_if_req = 1'b0;  i_if_addr = 32'h0;
    i_ls_req = 1'b0;  i_ls_we = 1'b0;  i_ls_be = 4'h0;
    i_ls_addr = 32'h0;  i_ls_wdata = 32'h0;
    i_mem_gnt = 1'b0;  i_mem_rvalid = 1'b0;  i_mem_rdata = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst_mem_req", {63'd0, o_mem_req}, 64'd0);
    chk("rst_mem_addr", {32'd0, o_mem_addr}, 64'd0);
    chk("rst_mem_be", {60'd0, o_mem_be}, 64'd0);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_if_rdata", {32'd0, o_if_rdata}, 64'd0);
    i_rst = 1'b0;
    tick();

    // 1. IF-only read of 0x100, response 2 cycles after grant
    i_if_req = 1'b1;  i_if_addr = 32'h0000_0100;
    #1;
    chk("t1_idle_req", {63'd0, o_mem_req}, 64'd0);
    tick();
    chk("t1_mem_req", {63'd0, o_mem_req}, 64'd1);
    chk("t1_addr", {32'd0, o_mem_addr}, 64'h100);
    chk("t1_we", {63'd0, o_mem_we}, 64'd0);
    chk("t1_be", {60'd0, o_mem_be}, 64'hF);
    chk("t1_nogt", {63'd0, o_if_gnt}, 64'd0);
    i_mem_gnt = 1'b1;
    #1;
    chk("t1_if_gnt", {63'd0, o_if_gnt}, 64'd1);
    chk("t1_ls_gnt", {63'd0, o_ls_gnt}, 64'd0);
    tick();
    i_mem_gnt = 1'b0;  i_if_req = 1'b0;
    chk("t1_gnt_pulse", {63'd0, o_if_gnt}, 64'd0);
    chk("t1_wait_busy", {63'd0, o_busy}, 64'd1);
    tick();
    i_mem_rvalid = 1'b1;  i_mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_rv_early", {63'd0, o_if_rvalid}, 64'd0);
    tick();
    i_mem_rvalid = 1'b0;
    chk("t1_if_rvalid", {63'd0, o_if_rvalid}, 64'd1);
    chk("t1_if_rdata", {32'd0, o_if_rdata}, 64'hDEAD_BEEF);
    chk("t1_ls_rvalid", {63'd0, o_ls_rvalid}, 64'd0);
    chk("t1_idle_busy", {63'd0, o_busy}, 64'd0);
    tick();
    chk("t1_rv_pulse", {63'd0, o_if_rvalid}, 64'd0);
    chk("t1_rdata_hold", {32'd0, o_if_rdata}, 64'hDEAD_BEEF);

    // 2. IF and LSU store raised together: LSU first, then IF
    i_if_req = 1'b1;
    i_ls_req = 1'b1;  i_ls_we = 1'b1;  i_ls_be = 4'b0011;
    i_ls_addr = 32'h0000_2000;  i_ls_wdata = 32'h1234_5678;
    tick();
    chk("t2_ls_we", {63'd0, o_mem_we}, 64'd1);
    chk("t2_ls_be", {60'd0, o_mem_be}, 64'h3);
    chk("t2_ls_addr", {32'd0, o_mem_addr}, 64'h2000);
    chk("t2_ls_wdata", {32'd0, o_mem_wdata}, 64'h1234_5678);
    serve("t2_ls", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t2_if_we", {63'd0, o_mem_we}, 64'd0);
    chk("t2_if_be", {60'd0, o_mem_be}, 64'hF);
    chk("t2_if_addr", {32'd0, o_mem_addr}, 64'h100);
    chk("t2_if_wdata", {32'd0, o_mem_wdata}, 64'd0);
    serve("t2_if", 1'b1, 32'hCAFE_0001, 1'b1, 1'b1, 1'b0);
    chk("t2_idle", {63'd0, o_busy}, 64'd0);

    // 3. Both held: LSU x4, IF, LSU x4, IF
    i_if_req = 1'b1;
    i_ls_req = 1'b1;  i_ls_we = 1'b0;  i_ls_be = 4'hF;  i_ls_addr = 32'h0000_3000;
    tick();
    for (int i = 0; i < 10; i++) begin
      logic exp_if;
      exp_if = (i == 4) || (i == 9);
      chk($sformatf("t3_addr%0d", i), {32'd0, o_mem_addr}, exp_if ? 64'h100 : 64'h3000);
      serve($sformatf("t3_x%0d", i), exp_if, 32'h3000_0000 + 32'(i), 1'b1, (i == 9), (i == 9));
    end
    chk("t3_idle", {63'd0, o_busy}, 64'd0);

    // 4. Grant withheld 3 cycles in REQ
    i_ls_req = 1'b1;  i_ls_we = 1'b0;  i_ls_addr = 32'h0000_4000;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4_req%0d", i), {63'd0, o_mem_req}, 64'd1);
      chk($sformatf("t4_addr%0d", i), {32'd0, o_mem_addr}, 64'h4000);
      chk($sformatf("t4_we%0d", i), {63'd0, o_mem_we}, 64'd0);
      chk($sformatf("t4_nogt%0d", i), {63'd0, o_ls_gnt}, 64'd0);
      tick();
    end
    serve("t4_ls", 1'b0, 32'h4444_4444, 1'b1, 1'b0, 1'b1);

    // 5. Reset in the middle of WAIT, late response after release
    i_ls_req = 1'b1;  i_ls_addr = 32'h0000_5000;
    tick();
    i_mem_gnt = 1'b1;
    #1;
    chk("t5_ls_gnt", {63'd0, o_ls_gnt}, 64'd1);
    tick();
    i_mem_gnt = 1'b0;  i_ls_req = 1'b0;
    tick();
    i_rst = 1'b1;
    #1;
    chk("t5_rst_busy", {63'd0, o_busy}, 64'd0);
    chk("t5_rst_req", {63'd0, o_mem_req}, 64'd0);
    chk("t5_rst_addr", {32'd0, o_mem_addr}, 64'd0);
    chk("t5_rst_rdata", {32'd0, o_ls_rdata}, 64'd0);
    chk("t5_rst_rvalid", {63'd0, o_ls_rvalid}, 64'd0);
    tick();
    i_rst = 1'b0;
    tick();
    tick();
    i_mem_rvalid = 1'b1;  i_mem_rdata = 32'h5555_5555;
    #1;
    chk("t5_late_busy", {63'd0, o_busy}, 64'd0);
    tick();
    i_mem_rvalid = 1'b0;
    chk("t5_late_rvalid", {63'd0, o_ls_rvalid}, 64'd0);
    chk("t5_late_rdata", {32'd0, o_ls_rdata}, 64'd0);
    chk("t5_late_busy2", {63'd0, o_busy}, 64'd0);

    // 6. Spurious gnt/rvalid in IDLE with no requests
    i_mem_gnt = 1'b1;  i_mem_rvalid = 1'b1;  i_mem_rdata = 32'h6666_6666;
    #1;
    chk("t6_if_gnt", {63'd0, o_if_gnt}, 64'd0);
    chk("t6_ls_gnt", {63'd0, o_ls_gnt}, 64'd0);
    chk("t6_req", {63'd0, o_mem_req}, 64'd0);
    tick();
    chk("t6_if_rvalid", {63'd0, o_if_rvalid}, 64'd0);
    chk("t6_ls_rvalid", {63'd0, o_ls_rvalid}, 64'd0);
    chk("t6_busy", {63'd0, o_busy}, 64'd0);
    i_mem_gnt = 1'b0;  i_mem_rvalid = 1'b0;
    tick();
    chk("t6_busy2", {63'd0, o_busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
